ctrl_spi_master: RTL
====================

CTRL_SPI_MASTER -- requirements
Module: ctrl_spi_master

Interface
REQ-001 SHALL have parameter fCLK, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter fSCLK, default 1_000_000, SPI clock frequency in Hz.
REQ-003 SHALL have parameter BITS, default 8, width of each control channel.
REQ-004 SHALL have parameter N_CH, default 8, channels per frame.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ch_data, input, N_CH*BITS, control values; channel 0 in the MSBs; order a16, a8, a5, a4, blend, delay, feedbk, gain.
REQ-008 SHALL have port go, input, 1, single-cycle frame start request.
REQ-009 SHALL have port busy, output, 1, high from the cycle after an accepted go until done.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at frame end.
REQ-011 SHALL have ports CTRL_SCLK, CTRL_MOSI and CTRL_SS_n, outputs, 1 each, SPI mode-0 bus to the a_ctrls receiver.

Function
REQ-012 SHALL derive HALF = fCLK/(2*fSCLK); elaboration SHALL fail if HALF is non-integer or <1.
REQ-013 SHALL implement FSM states IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD and GAP.
REQ-014 In IDLE, go SHALL latch ch_data into a shift register, drive CTRL_SS_n low and CTRL_MOSI to frame bit 0 (channel 0 MSB) on the next cycle, and enter SETUP.
REQ-015 SETUP SHALL last HALF cycles; SHIFT_HI SHALL drive CTRL_SCLK high for HALF cycles; SHIFT_LO SHALL drive CTRL_SCLK low for HALF cycles.
REQ-016 CTRL_MOSI SHALL change only on the cycle CTRL_SCLK falls; data is MSB first, channel 0 first.
REQ-017 A bit counter SHALL count frame bits; after the last falling edge the FSM SHALL enter HOLD for HALF cycles.
REQ-018 On leaving HOLD, CTRL_SS_n SHALL rise and done SHALL pulse in the same cycle, then the FSM SHALL enter GAP.
REQ-019 GAP SHALL keep CTRL_SS_n high for 2*HALF cycles, then enter IDLE.
REQ-020 go SHALL be ignored outside IDLE, including during GAP; ch_data changes after latch SHALL not affect the frame.
REQ-021 CTRL_SS_n SHALL stay low for exactly (2*FRAME_BITS+2)*HALF cycles, where FRAME_BITS = N_CH*BITS, or N_CH*BITS+BITS with CTRL_SPI_CSUM_EN defined.
REQ-022 CTRL_SCLK SHALL idle low, and CTRL_MOSI SHALL idle low whenever CTRL_SS_n is high.

Reset
REQ-023 On reset_n low, all of the following SHALL take effect immediately, including mid-frame: CTRL_SS_n=1, CTRL_SCLK=0, CTRL_MOSI=0, busy=0, done=0, FSM=IDLE, counters=0.
REQ-024 No go SHALL be accepted in the first cycle after reset_n is released.

Configuration
REQ-025 With CTRL_SPI_CSUM_EN defined, one trailing BITS-wide byte SHALL be appended to each frame, equal to the XOR of all channels.
REQ-026 Without CTRL_SPI_CSUM_EN, the frame SHALL be exactly N_CH*BITS bits and no checksum logic SHALL exist.

Structure
REQ-027 Package ctrl_spi_pkg SHALL hold the channel-index enum (CH_A16..CH_GAIN), the defaults for N_CH and BITS, and the FSM state typedef.
REQ-028 Sub-module ctrl_spi_clkdiv SHALL generate the HALF-period tick; it SHALL be reset when SETUP is entered so that the first edge is aligned.

Verification (fSCLK=5_000_000, HALF=5)
REQ-029 go with ch_data=0x01_02_04_08_10_20_40_80 -> a bit-sampling model at CTRL_SCLK rise decodes the same 8 bytes; CTRL_SS_n is low for 650 cycles; done pulses once.
REQ-030 go pulsed again at cycles 10, 300 and during GAP -> ignored; exactly one frame is sent; the next go after GAP starts a new frame.
REQ-031 reset_n asserted at cycle 200 of a frame -> CTRL_SS_n=1, CTRL_SCLK=0, busy=0 immediately; a subsequent go sends a clean full frame.
REQ-032 With CTRL_SPI_CSUM_EN, ch_data all 0xFF -> 9th byte is 0x00 and CTRL_SS_n is low for 730 cycles; with ch_data=0x01_00_00_00_00_00_00_02 -> checksum is 0x03.
REQ-033 Back-to-back loopback into an a_ctrls instance with ch_data changed after go -> the receiver outputs the values latched at go; CTRL_SS_n high time is at least 10 cycles.

Source files
------------

// File: rtl/ctrl_spi_pkg.sv
// Shared types and defaults for the control-channel SPI master.
package ctrl_spi_pkg;

    typedef enum logic [2:0] {
        CH_A16    = 3'd0,
        CH_A8     = 3'd1,
        CH_A5     = 3'd2,
        CH_A4     = 3'd3,
        CH_BLEND  = 3'd4,
        CH_DELAY  = 3'd5,
        CH_FEEDBK = 3'd6,
        CH_GAIN   = 3'd7
    } ch_idx_e;

    localparam int DEF_N_CH = 8;
    localparam int DEF_BITS = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        HOLD     = 3'd4,
        GAP      = 3'd5
    } state_e;

    // SCLK half period must be a whole, non-zero number of system clocks.
    function automatic bit half_valid(input int fclk, input int fsclk);
        int half;
        half = fclk / (2 * fsclk);
        return (half >= 1) && (half * 2 * fsclk == fclk);
    endfunction

endpackage

// File: rtl/ctrl_spi_clkdiv.sv
// Half-SCLK-period tick generator; clr restarts the count so the first edge lands HALF cycles later.
module ctrl_spi_clkdiv #(
    parameter int HALF = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || !en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/ctrl_spi_master.sv
// Mode-0 SPI master that ships one frame of N_CH control channels to the a_ctrls receiver.
// Define CTRL_SPI_CSUM_EN to append an XOR checksum channel to every frame.
module ctrl_spi_master
    import ctrl_spi_pkg::*;
#(
    parameter int fCLK  = 50_000_000,
    parameter int fSCLK = 1_000_000,
    parameter int BITS  = DEF_BITS,
    parameter int N_CH  = DEF_N_CH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_CH*BITS-1:0] ch_data,
    input  logic                 go,
    output logic                 busy,
    output logic                 done,
    output logic                 CTRL_SCLK,
    output logic                 CTRL_MOSI,
    output logic                 CTRL_SS_n
);

    localparam int HALF = fCLK / (2 * fSCLK);
`ifdef CTRL_SPI_CSUM_EN
    localparam int FB = N_CH * BITS + BITS;
`else
    localparam int FB = N_CH * BITS;
`endif
    localparam int BW = $clog2(FB);

    if (!half_valid(fCLK, fSCLK)) begin : g_bad_half
        $error("ctrl_spi_master: fCLK/(2*fSCLK) must be an integer >= 1");
    end

    state_e          state, state_nxt;
    logic            accept, fall, finish, tick, last_bit, armed, gap_ph, active;
    logic [BW-1:0]   bit_cnt;
    logic [FB-1:0]   sreg, frame;

`ifdef CTRL_SPI_CSUM_EN
    logic [BITS-1:0] csum;

    always_comb begin
        csum = '0;
        for (int i = 0; i < N_CH; i++) csum = csum ^ ch_data[i*BITS +: BITS];
    end

    assign frame = {ch_data, csum};
`else
    assign frame = ch_data;
`endif

    assign last_bit = (bit_cnt == BW'(FB - 1));

    ctrl_spi_clkdiv #(.HALF(HALF)) u_clkdiv (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .en      (state != IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fall      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE:     if (go && armed) begin
                          accept    = 1'b1;
                          state_nxt = SETUP;
                      end
            SETUP:    if (tick) state_nxt = SHIFT_HI;
            SHIFT_HI: if (tick) begin
                          fall      = 1'b1;
                          state_nxt = SHIFT_LO;
                      end
            SHIFT_LO: if (tick) state_nxt = last_bit ? HOLD : SHIFT_HI;
            HOLD:     if (tick) begin
                          finish    = 1'b1;
                          state_nxt = GAP;
                      end
            GAP:      if (tick && gap_ph) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign active = state_nxt inside {SETUP, SHIFT_HI, SHIFT_LO, HOLD};

    // Bus pins are registered from the next state so they switch glitch-free with the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed     <= 1'b0;
            gap_ph    <= 1'b0;
            bit_cnt   <= '0;
            sreg      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            CTRL_SCLK <= 1'b0;
            CTRL_MOSI <= 1'b0;
            CTRL_SS_n <= 1'b1;
        end else begin
            armed     <= 1'b1;
            done      <= finish;
            busy      <= active;
            CTRL_SS_n <= !active;
            CTRL_SCLK <= (state_nxt == SHIFT_HI);

            // Zeros shift in behind the data, so MOSI is low again after the last fall.
            if (accept) begin
                sreg      <= frame;
                CTRL_MOSI <= frame[FB-1];
            end else if (fall) begin
                sreg      <= sreg << 1;
                CTRL_MOSI <= sreg[FB-2];
            end

            if (accept)                                bit_cnt <= '0;
            else if (state == SHIFT_LO && tick && !last_bit) bit_cnt <= bit_cnt + 1'b1;

            if (finish)                     gap_ph <= 1'b0;
            else if (state == GAP && tick)  gap_ph <= 1'b1;
        end
    end

endmodule
